// File: rtl/risc_result_tracer_pkg.sv
// Shared types for the result tracer: FSM states and the {pc, res} entry layout.
// Entry occupies 64 bits with pc in [63:32] and res in [31:0].
package risc_result_tracer_pkg;

    localparam int ENT_W = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_PC  = 2'd1,
        SEND_RES = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] res;
    } entry_t;

endpackage

// File: rtl/risc_result_tracer_if.sv
// Two-beat 32-bit valid/ready trace stream.
// Beat 0 carries PC, beat 1 (last) carries the result.
interface risc_result_tracer_if;

    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/risc_result_tracer_fifo.sv
// Synchronous 64-bit x DEPTH FIFO with combinational flags from count.
// Caller guarantees no push when full unless a pop happens in the same cycle.
module trace_fifo
    import risc_result_tracer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [ENT_W-1:0] din,
    output logic [ENT_W-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [ENT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/risc_result_tracer.sv
// Captures {PC, resOut} whenever the core result changes and streams each
// entry as a PC beat followed by a result beat.
module risc_result_tracer
    import risc_result_tracer_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4,
    parameter int DROP_W = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  en,
    input  logic [31:0]           PC,
    input  logic [31:0]           resOut,
    risc_result_tracer_if.master  stream,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic [DROP_W-1:0]     drop_cnt
);

    state_t      state;
    state_t      state_nxt;
    entry_t      head;
    logic        seen;
    logic [31:0] last_res;
    logic        cap;
    logic        push;
    logic        pop;
    logic        drop;
    logic        full;
    logic        empty;

    assign cap  = en & (~seen | (resOut != last_res));
    assign pop  = (state == SEND_RES) & stream.out_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push = cap & (~full | pop);
    assign drop = cap & full & ~pop;

    trace_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST),
        .push  (push),
        .pop   (pop),
        .din   ({PC, resOut}),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            seen     <= 1'b0;
            last_res <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (cap) begin
                seen     <= 1'b1;
                last_res <= resOut;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        stream.out_valid = 1'b0;
        stream.out_last  = 1'b0;
        stream.out_data  = '0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = SEND_PC;
                end
            end
            SEND_PC: begin
                stream.out_valid = 1'b1;
                stream.out_data  = head.pc;
                if (stream.out_ready) begin
                    state_nxt = SEND_RES;
                end
            end
            SEND_RES: begin
                stream.out_valid = 1'b1;
                stream.out_last  = 1'b1;
                stream.out_data  = head.res;
                if (stream.out_ready) begin
                    state_nxt = (count > CNT_W'(1)) ? SEND_PC : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_risc_result_tracer.sv
// Directed bench for risc_result_tracer: capture, stream order, overflow,
// full push/pop, stall stability, async reset and enable gating.
module tb_risc_result_tracer;

    logic        CLK;
    logic        RST;
    logic        en;
    logic [31:0] PC;
    logic [31:0] resOut;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;
    int          checks;
    int          errors;

    risc_result_tracer_if bus ();

    risc_result_tracer dut (
        .CLK      (CLK),
        .RST      (RST),
        .en       (en),
        .PC       (PC),
        .resOut   (resOut),
        .stream   (bus.master),
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic beat(input string tag, input logic [31:0] d,
                        input logic l);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_data"}, 64'(bus.out_data), 64'(d));
        check({tag, "_last"}, 64'(bus.out_last), 64'(l));
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        RST           = 1'b0;
        en            = 1'b0;
        PC            = '0;
        resOut        = '0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        @(negedge CLK);
        RST = 1'b1;

        // 1: 5,5,5 then 9
        en = 1'b1; PC = 32'd0; resOut = 32'd5; bus.out_ready = 1'b1;
        step();
        check("t1_cnt1", 64'(count), 64'd1);
        check("t1_nv", 64'(bus.out_valid), 64'd0);
        step();
        beat("t1_pc0", 32'd0, 1'b0);
        step();
        beat("t1_res5", 32'd5, 1'b1);
        PC = 32'd8; resOut = 32'd9;
        step();
        check("t1_cnt_pp", 64'(count), 64'd1);
        check("t1_idle", 64'(bus.out_valid), 64'd0);
        step();
        beat("t1_pc8", 32'd8, 1'b0);
        step();
        beat("t1_res9", 32'd9, 1'b1);
        step();
        check("t1_empty", 64'(count), 64'd0);
        check("t1_end_nv", 64'(bus.out_valid), 64'd0);

        // 2: fill, overflow, drain in order
        bus.out_ready = 1'b0;
        for (int v = 1; v <= 8; v++) begin
            PC = 32'(100 + v); resOut = 32'(v);
            step();
        end
        check("t2_cnt8", 64'(count), 64'd8);
        check("t2_noovf", 64'(overflow), 64'd0);
        PC = 32'd109; resOut = 32'd9;
        step();
        check("t2_cnt_full", 64'(count), 64'd8);
        check("t2_ovf", 64'(overflow), 64'd1);
        check("t2_drop1", 64'(drop_cnt), 64'd1);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            beat("t2_pc", 32'(100 + i), 1'b0);
            step();
            beat("t2_res", 32'(i), 1'b1);
            step();
        end
        check("t2_drained", 64'(count), 64'd0);
        check("t2_idle", 64'(bus.out_valid), 64'd0);

        // 3: full in SEND_RES, pop and push together
        bus.out_ready = 1'b0;
        for (int v = 'h11; v <= 'h18; v++) begin
            PC = 32'('h200 + v); resOut = 32'(v);
            step();
        end
        check("t3_cnt8", 64'(count), 64'd8);
        beat("t3_head_pc", 32'h211, 1'b0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        beat("t3_head_res", 32'h11, 1'b1);
        bus.out_ready = 1'b1; PC = 32'h219; resOut = 32'h19;
        step();
        check("t3_cnt_same", 64'(count), 64'd8);
        check("t3_drop_same", 64'(drop_cnt), 64'd1);
        beat("t3_next_pc", 32'h212, 1'b0);

        // 4: stall after PC beat
        step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            beat("t4_hold", 32'h12, 1'b1);
            step();
        end
        beat("t4_hold_end", 32'h12, 1'b1);

        // 5: async reset in SEND_PC
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        beat("t5_pre", 32'h213, 1'b0);
        check("t5_cnt7", 64'(count), 64'd7);
        #2;
        RST = 1'b0;
        #1;
        check("t5_async_nv", 64'(bus.out_valid), 64'd0);
        check("t5_async_cnt", 64'(count), 64'd0);
        check("t5_async_ovf", 64'(overflow), 64'd0);
        check("t5_async_drop", 64'(drop_cnt), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        bus.out_ready = 1'b1;
        step();
        check("t5_recap", 64'(count), 64'd1);
        step();
        beat("t5_pc", 32'h219, 1'b0);
        step();
        beat("t5_res", 32'h19, 1'b1);
        step();
        check("t5_drained", 64'(count), 64'd0);

        // 6: enable gating
        en = 1'b0;
        resOut = 32'h30;
        step();
        resOut = 32'h31;
        step();
        check("t6_en0", 64'(count), 64'd0);
        en = 1'b1; resOut = 32'h19;
        step();
        check("t6_same", 64'(count), 64'd0);
        check("t6_same_nv", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0; resOut = 32'h31;
        step();
        check("t6_change", 64'(count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
